// File: rtl/system_types_pkg.sv
// ============================================================================
//  Module   : system_types_pkg
//  Purpose  : Shared dcache address, access-source and fill geometry types.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package system_types_pkg;

  localparam int DCACHE_TAG_WIDTH          = 22;
  localparam int DCACHE_INDEX_WIDTH        = 6;
  localparam int DCACHE_BANK_WIDTH         = 1;
  localparam int DCACHE_BLOCK_OFFSET_WIDTH = 5;
  localparam int DCACHE_NUM_BANKS          = 2;

  // Sizes in bits: a 256-bit block is moved as 32-bit data words.
  localparam int DCACHE_BLOCK_SIZE      = 256;
  localparam int DCACHE_DATA_WORD_WIDTH = 32;

  localparam int DCACHE_FILL_BEATS      = DCACHE_BLOCK_SIZE / DCACHE_DATA_WORD_WIDTH;
  localparam int DCACHE_FILL_BEAT_WIDTH = $clog2(DCACHE_FILL_BEATS);

  localparam int DCACHE_DATA_WORD_INDEX_WIDTH = DCACHE_INDEX_WIDTH + DCACHE_FILL_BEAT_WIDTH;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]          tag;
    logic [DCACHE_INDEX_WIDTH-1:0]        index;
    logic [DCACHE_BANK_WIDTH-1:0]         bank;
    logic [DCACHE_BLOCK_OFFSET_WIDTH-1:0] block_offset;
  } dcache_PA_t;

  typedef enum logic [1:0] {
    LD   = 2'd0,
    ST   = 2'd1,
    FILL = 2'd2
  } dcache_access_src_t;

  // Data-array row of the 32-bit word addressed by a load/store.
  function automatic logic [DCACHE_DATA_WORD_INDEX_WIDTH-1:0] dcache_row(input dcache_PA_t pa);
    return {pa.index, pa.block_offset[4:2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_bank_arbiter.sv
// ============================================================================
//  Module   : dcache_bank_arbiter
//  Purpose  : Per-bank arbitration of load, store and block-fill accesses to
//             a two-bank dcache data array, with store anti-starvation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_bank_arbiter
  import system_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  logic                                      ld_req_valid,
  input  dcache_PA_t                                ld_req_PA,
  output logic                                      ld_req_ready,
  input  logic                                      st_req_valid,
  input  dcache_PA_t                                st_req_PA,
  output logic                                      st_req_ready,
  input  logic                                      fill_req_valid,
  input  dcache_PA_t                                fill_req_PA,
  output logic                                      fill_req_ready,
  output logic                                      fill_beat_valid,
  output logic [DCACHE_FILL_BEAT_WIDTH-1:0]         fill_beat_idx,
  output logic [1:0]                                bank_access_valid,
  output dcache_access_src_t [1:0]                  bank_access_src,
  output logic [1:0][DCACHE_DATA_WORD_INDEX_WIDTH-1:0] bank_access_row
);

  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [DCACHE_FILL_BEAT_WIDTH-1:0] c_LAST_BEAT =
    DCACHE_FILL_BEAT_WIDTH'(DCACHE_FILL_BEATS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

  fill_state_t                              r_state, w_state_next;
  logic [DCACHE_FILL_BEAT_WIDTH-1:0]        r_beat, w_beat_next;
  logic [DCACHE_INDEX_WIDTH-1:0]            r_fill_index, w_fill_index_next;
  logic                                     r_fill_bank, w_fill_bank_next;
  logic [c_STARVE_W-1:0]                    r_starve_cnt, w_starve_cnt_next;

  logic                                     w_filling;
  logic                                     w_fill_accept;
  logic                                     w_st_force;
  logic [1:0]                               w_locked;
  logic [1:0]                               w_ld_gnt;
  logic [1:0]                               w_st_gnt;
  logic [DCACHE_DATA_WORD_INDEX_WIDTH-1:0]  w_ld_row, w_st_row, w_fill_row;
  logic                                     w_unused;

  assign w_filling     = (r_state == S_FILL);
  assign fill_req_ready = nRST && (r_state == S_IDLE);
  assign w_fill_accept = fill_req_valid && fill_req_ready;
  assign w_st_force    = (r_starve_cnt == c_STARVE_W'(STARVE_LIMIT));

  assign w_ld_row   = dcache_row(ld_req_PA);
  assign w_st_row   = dcache_row(st_req_PA);
  assign w_fill_row = {r_fill_index, r_beat};

  assign fill_beat_valid = nRST && w_filling;
  assign fill_beat_idx   = r_beat;

  // Fields that do not take part in bank arbitration.
  assign w_unused = ^{ld_req_PA.tag, ld_req_PA.block_offset[1:0],
                      st_req_PA.tag, st_req_PA.block_offset[1:0],
                      fill_req_PA.tag, fill_req_PA.block_offset};

  generate
    for (genvar b = 0; b < DCACHE_NUM_BANKS; b++) begin : g_bank
      logic w_ld_hit;
      logic w_st_hit;

      // The lock follows the registered state, so the accept cycle is still open.
      assign w_locked[b] = w_filling && (r_fill_bank == 1'(b));
      assign w_ld_hit    = nRST && ld_req_valid && (ld_req_PA.bank == 1'(b)) && !w_locked[b];
      assign w_st_hit    = nRST && st_req_valid && (st_req_PA.bank == 1'(b)) && !w_locked[b];

      assign w_ld_gnt[b] = w_ld_hit && !(w_st_hit && w_st_force);
      assign w_st_gnt[b] = w_st_hit && (!w_ld_hit || w_st_force);

      assign bank_access_valid[b] = nRST && (w_locked[b] || w_ld_gnt[b] || w_st_gnt[b]);
      assign bank_access_src[b]   = w_locked[b] ? FILL : (w_ld_gnt[b] ? LD : ST);
      assign bank_access_row[b]   = w_locked[b] ? w_fill_row :
                                    (w_ld_gnt[b] ? w_ld_row : w_st_row);
    end
  endgenerate

  assign ld_req_ready = |w_ld_gnt;
  assign st_req_ready = |w_st_gnt;

  // Only ld-conflict losses age a store; a fill-locked bank freezes the count.
  always_comb begin
    w_starve_cnt_next = r_starve_cnt;
    if (!st_req_valid || st_req_ready) begin
      w_starve_cnt_next = '0;
    end else if (w_locked[st_req_PA.bank]) begin
      w_starve_cnt_next = r_starve_cnt;
    end else if (!w_st_force) begin
      w_starve_cnt_next = r_starve_cnt + c_STARVE_W'(1);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_beat_next       = r_beat;
    w_fill_index_next = r_fill_index;
    w_fill_bank_next  = r_fill_bank;
    case (r_state)
      S_IDLE: begin
        if (w_fill_accept) begin
          w_state_next      = S_FILL;
          w_beat_next       = '0;
          w_fill_index_next = fill_req_PA.index;
          w_fill_bank_next  = fill_req_PA.bank;
        end
      end
      S_FILL: begin
        w_beat_next = r_beat + DCACHE_FILL_BEAT_WIDTH'(1);
        if (r_beat == c_LAST_BEAT) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_fill_index <= '0;
      r_fill_bank  <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_beat       <= w_beat_next;
      r_fill_index <= w_fill_index_next;
      r_fill_bank  <= w_fill_bank_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_bank_arbiter.sv
// ============================================================================
//  Module   : tb_dcache_bank_arbiter
//  Purpose  : Directed scenarios plus randomized traffic against a cycle model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_bank_arbiter;
  import system_types_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic                                        CLK = 1'b0;
  logic                                        nRST = 1'b0;
  logic                                        ld_req_valid, st_req_valid, fill_req_valid;
  dcache_PA_t                                  ld_req_PA, st_req_PA, fill_req_PA;
  logic                                        ld_req_ready, st_req_ready, fill_req_ready;
  logic                                        fill_beat_valid;
  logic [DCACHE_FILL_BEAT_WIDTH-1:0]           fill_beat_idx;
  logic [1:0]                                  bank_access_valid;
  dcache_access_src_t [1:0]                    bank_access_src;
  logic [1:0][DCACHE_DATA_WORD_INDEX_WIDTH-1:0] bank_access_row;

  int n_vec = 0;
  int n_err = 0;

  dcache_bank_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .ld_req_valid(ld_req_valid), .ld_req_PA(ld_req_PA), .ld_req_ready(ld_req_ready),
    .st_req_valid(st_req_valid), .st_req_PA(st_req_PA), .st_req_ready(st_req_ready),
    .fill_req_valid(fill_req_valid), .fill_req_PA(fill_req_PA), .fill_req_ready(fill_req_ready),
    .fill_beat_valid(fill_beat_valid), .fill_beat_idx(fill_beat_idx),
    .bank_access_valid(bank_access_valid), .bank_access_src(bank_access_src),
    .bank_access_row(bank_access_row)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic dcache_PA_t make_pa(input logic [5:0] idx, input logic bank,
                                         input logic [4:0] off);
    dcache_PA_t p;
    p.tag          = 22'($urandom);
    p.index        = idx;
    p.bank         = bank;
    p.block_offset = off;
    return p;
  endfunction

  task automatic drive(input logic ldv, input dcache_PA_t ldpa, input logic stv,
                       input dcache_PA_t stpa, input logic fv, input dcache_PA_t fpa);
    ld_req_valid = ldv;  ld_req_PA = ldpa;
    st_req_valid = stv;  st_req_PA = stpa;
    fill_req_valid = fv; fill_req_PA = fpa;
  endtask

  task automatic idle_inputs();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive(1'b1, make_pa(6'd1, 1'b0, 5'd0), 1'b1, make_pa(6'd2, 1'b1, 5'd0),
          1'b1, make_pa(6'd3, 1'b0, 5'd0));
    sample();
    n_vec++;
    if ({ld_req_ready, st_req_ready, fill_req_ready, fill_beat_valid, bank_access_valid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000000",
               {ld_req_ready, st_req_ready, fill_req_ready, fill_beat_valid, bank_access_valid});
    end
    next_cycle();
    next_cycle();
    nRST = 1'b1;
    idle_inputs();
    sample();
    n_vec++;
    if ({fill_req_ready, fill_beat_valid, bank_access_valid, ld_req_ready, st_req_ready} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_release: got %b want 100000",
               {fill_req_ready, fill_beat_valid, bank_access_valid, ld_req_ready, st_req_ready});
    end
    next_cycle();
  endtask

  task automatic test_dual_bank();
    drive(1'b1, make_pa(6'h05, 1'b0, 5'h0C), 1'b1, make_pa(6'h11, 1'b1, 5'h1C), 1'b0, '0);
    sample();
    n_vec++;
    if ({ld_req_ready, st_req_ready, bank_access_valid} !== 4'b1111) begin
      n_err++;
      $display("FAIL dual_ready: got %b want 1111", {ld_req_ready, st_req_ready, bank_access_valid});
    end
    n_vec++;
    if (bank_access_src[1] !== ST || bank_access_src[0] !== LD) begin
      n_err++;
      $display("FAIL dual_src: got %0d,%0d want %0d,%0d", bank_access_src[1], bank_access_src[0], ST, LD);
    end
    n_vec++;
    if (bank_access_row[1] !== 9'h08F || bank_access_row[0] !== 9'h02B) begin
      n_err++;
      $display("FAIL dual_row: got %h,%h want 08f,02b", bank_access_row[1], bank_access_row[0]);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_fill();
    drive(1'b0, '0, 1'b0, '0, 1'b1, make_pa(6'h2A, 1'b1, 5'h13));
    sample();
    n_vec++;
    if ({fill_req_ready, fill_beat_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL fill_accept: got %b want 10", {fill_req_ready, fill_beat_valid});
    end
    next_cycle();
    for (int beat = 0; beat < 8; beat++) begin
      logic lb;
      lb = (beat % 2 == 0);
      drive(1'b1, make_pa(6'(beat), lb, 5'd4), 1'b0, '0, 1'b1, make_pa(6'h15, 1'b0, 5'd0));
      sample();
      n_vec++;
      if ({fill_beat_valid, fill_beat_idx, fill_req_ready} !== {1'b1, 3'(beat), 1'b0}) begin
        n_err++;
        $display("FAIL fill_beat%0d: got v=%b idx=%0d rdy=%b want v=1 idx=%0d rdy=0",
                 beat, fill_beat_valid, fill_beat_idx, fill_req_ready, beat);
      end
      n_vec++;
      if (bank_access_valid[1] !== 1'b1 || bank_access_src[1] !== FILL ||
          bank_access_row[1] !== 9'(9'h150 + beat)) begin
        n_err++;
        $display("FAIL fill_bank1_beat%0d: got v=%b src=%0d row=%h want v=1 src=2 row=%h",
                 beat, bank_access_valid[1], bank_access_src[1], bank_access_row[1], 9'h150 + beat);
      end
      n_vec++;
      if ({ld_req_ready, bank_access_valid[0]} !== {!lb, !lb}) begin
        n_err++;
        $display("FAIL fill_ld_beat%0d: got rdy=%b v0=%b want %b", beat, ld_req_ready,
                 bank_access_valid[0], !lb);
      end
      next_cycle();
    end
    idle_inputs();
    sample();
    n_vec++;
    if ({fill_req_ready, fill_beat_valid, bank_access_valid} !== 4'b1000) begin
      n_err++;
      $display("FAIL fill_done: got %b want 1000", {fill_req_ready, fill_beat_valid, bank_access_valid});
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    dcache_PA_t pa;
    pa = make_pa(6'd9, 1'b0, 5'h08);
    drive(1'b1, pa, 1'b1, pa, 1'b0, '0);
    for (int c = 0; c < 10; c++) begin
      logic exp_st;
      exp_st = (c == STARVE_LIMIT) || (c == 2 * STARVE_LIMIT + 1);
      sample();
      n_vec++;
      if ({ld_req_ready, st_req_ready, bank_access_valid} !== {!exp_st, exp_st, 2'b01} ||
          bank_access_src[0] !== (exp_st ? ST : LD)) begin
        n_err++;
        $display("FAIL starve_c%0d: got ld=%b st=%b v=%b src=%0d want ld=%b st=%b v=01",
                 c, ld_req_ready, st_req_ready, bank_access_valid, bank_access_src[0], !exp_st, exp_st);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_fill_accept_ld();
    dcache_PA_t pa;
    pa = make_pa(6'd3, 1'b0, 5'h04);
    drive(1'b1, pa, 1'b0, '0, 1'b1, make_pa(6'd3, 1'b0, 5'd0));
    sample();
    n_vec++;
    if ({ld_req_ready, fill_req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL accept_ld: got %b want 11", {ld_req_ready, fill_req_ready});
    end
    next_cycle();
    drive(1'b1, pa, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      sample();
      n_vec++;
      if (ld_req_ready !== 1'b0 || bank_access_src[0] !== FILL) begin
        n_err++;
        $display("FAIL accept_lock%0d: got rdy=%b src=%0d want rdy=0 src=2", i, ld_req_ready,
                 bank_access_src[0]);
      end
      next_cycle();
    end
    sample();
    n_vec++;
    if (ld_req_ready !== 1'b1 || bank_access_src[0] !== LD || bank_access_row[0] !== 9'h019) begin
      n_err++;
      $display("FAIL accept_unlock: got rdy=%b src=%0d row=%h want rdy=1 src=0 row=019",
               ld_req_ready, bank_access_src[0], bank_access_row[0]);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid_fill();
    drive(1'b0, '0, 1'b0, '0, 1'b1, make_pa(6'd7, 1'b1, 5'd0));
    sample();
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      sample();
      n_vec++;
      if ({fill_beat_valid, fill_beat_idx} !== {1'b1, 3'(i)}) begin
        n_err++;
        $display("FAIL rstfill_beat%0d: got v=%b idx=%0d", i, fill_beat_valid, fill_beat_idx);
      end
      if (i != 3) next_cycle();
    end
    nRST = 1'b0;
    next_cycle();
    sample();
    n_vec++;
    if ({fill_beat_valid, fill_req_ready, bank_access_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL rstfill_during: got %b want 0000", {fill_beat_valid, fill_req_ready, bank_access_valid});
    end
    next_cycle();
    nRST = 1'b1;
    sample();
    n_vec++;
    if ({fill_beat_valid, fill_req_ready, bank_access_valid} !== 4'b0100) begin
      n_err++;
      $display("FAIL rstfill_after: got %b want 0100", {fill_beat_valid, fill_req_ready, bank_access_valid});
    end
    next_cycle();
  endtask

  task automatic test_store_during_fill();
    dcache_PA_t pa;
    pa = make_pa(6'd1, 1'b0, 5'h10);
    drive(1'b0, '0, 1'b0, '0, 1'b1, make_pa(6'd1, 1'b0, 5'd0));
    sample();
    next_cycle();
    drive(1'b0, '0, 1'b1, pa, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      sample();
      n_vec++;
      if (st_req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stlock_%0d: got st=%b want 0", i, st_req_ready);
      end
      next_cycle();
    end
    sample();
    n_vec++;
    if (st_req_ready !== 1'b1 || bank_access_src[0] !== ST) begin
      n_err++;
      $display("FAIL stlock_release: got st=%b src=%0d want st=1 src=1", st_req_ready, bank_access_src[0]);
    end
    next_cycle();
    // Both held through a lock: a frozen counter means ld still wins first.
    drive(1'b0, '0, 1'b0, '0, 1'b1, make_pa(6'd2, 1'b0, 5'd0));
    sample();
    next_cycle();
    drive(1'b1, pa, 1'b1, pa, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      sample();
      n_vec++;
      if ({ld_req_ready, st_req_ready} !== 2'b00) begin
        n_err++;
        $display("FAIL stlock2_%0d: got %b want 00", i, {ld_req_ready, st_req_ready});
      end
      next_cycle();
    end
    for (int c = 0; c <= STARVE_LIMIT; c++) begin
      logic exp_st;
      exp_st = (c == STARVE_LIMIT);
      sample();
      n_vec++;
      if ({ld_req_ready, st_req_ready} !== {!exp_st, exp_st}) begin
        n_err++;
        $display("FAIL stlock2_post%0d: got %b want %b", c, {ld_req_ready, st_req_ready}, {!exp_st, exp_st});
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    int m_left, m_idx, m_bank, m_starve;
    nRST = 1'b0;
    idle_inputs();
    next_cycle();
    nRST = 1'b1;
    m_left = 0; m_idx = 0; m_bank = 0; m_starve = 0;
    for (int n = 0; n < 600; n++) begin
      logic rst_n, ldv, stv, fv, ld_ok, st_ok;
      dcache_PA_t lpa, spa, fpa;
      int e_valid[2], e_src[2], e_row[2];
      rst_n = ($urandom_range(0, 59) != 0);
      ldv = ($urandom_range(0, 9) < 6);
      stv = ($urandom_range(0, 9) < 7);
      fv  = ($urandom_range(0, 5) == 0);
      lpa = make_pa(6'($urandom_range(0, 3)), 1'($urandom), 5'($urandom));
      spa = make_pa(6'($urandom_range(0, 3)), 1'($urandom), 5'($urandom));
      fpa = make_pa(6'($urandom), 1'($urandom), 5'($urandom));
      nRST = rst_n;
      drive(ldv, lpa, stv, spa, fv, fpa);
      sample();

      ld_ok = rst_n && ldv && !(m_left > 0 && int'(lpa.bank) == m_bank);
      st_ok = rst_n && stv && !(m_left > 0 && int'(spa.bank) == m_bank);
      if (ld_ok && st_ok && lpa.bank == spa.bank) begin
        if (m_starve == STARVE_LIMIT) ld_ok = 1'b0;
        else st_ok = 1'b0;
      end
      for (int b = 0; b < 2; b++) begin
        e_valid[b] = 0; e_src[b] = 0; e_row[b] = 0;
        if (!rst_n) begin
          e_valid[b] = 0;
        end else if (m_left > 0 && m_bank == b) begin
          e_valid[b] = 1; e_src[b] = 2; e_row[b] = m_idx * 8 + (8 - m_left);
        end else if (ld_ok && int'(lpa.bank) == b) begin
          e_valid[b] = 1; e_src[b] = 0; e_row[b] = int'(lpa.index) * 8 + int'(lpa.block_offset) / 4;
        end else if (st_ok && int'(spa.bank) == b) begin
          e_valid[b] = 1; e_src[b] = 1; e_row[b] = int'(spa.index) * 8 + int'(spa.block_offset) / 4;
        end
      end

      n_vec++;
      if ({ld_req_ready, st_req_ready, fill_req_ready, fill_beat_valid} !==
          {ld_ok, st_ok, rst_n && m_left == 0, rst_n && m_left > 0}) begin
        n_err++;
        $display("FAIL rand%0d_hs: got %b want %b", n,
                 {ld_req_ready, st_req_ready, fill_req_ready, fill_beat_valid},
                 {ld_ok, st_ok, rst_n && m_left == 0, rst_n && m_left > 0});
      end
      if (rst_n && m_left > 0) begin
        n_vec++;
        if (fill_beat_idx !== 3'(8 - m_left)) begin
          n_err++;
          $display("FAIL rand%0d_beat: got %0d want %0d", n, fill_beat_idx, 8 - m_left);
        end
      end
      for (int b = 0; b < 2; b++) begin
        n_vec++;
        if (bank_access_valid[b] !== 1'(e_valid[b]) ||
            (e_valid[b] == 1 && (int'(bank_access_src[b]) != e_src[b] ||
                                 bank_access_row[b] !== 9'(e_row[b])))) begin
          n_err++;
          $display("FAIL rand%0d_bank%0d: got v=%b src=%0d row=%h want v=%0d src=%0d row=%h",
                   n, b, bank_access_valid[b], bank_access_src[b], bank_access_row[b],
                   e_valid[b], e_src[b], 9'(e_row[b]));
        end
      end

      if (!rst_n) begin
        m_left = 0; m_idx = 0; m_bank = 0; m_starve = 0;
      end else begin
        if (!stv || st_ok) m_starve = 0;
        else if (m_left > 0 && int'(spa.bank) == m_bank) m_starve = m_starve;
        else if (m_starve < STARVE_LIMIT) m_starve++;
        if (m_left > 0) begin
          m_left--;
        end else if (fv) begin
          m_left = 8; m_idx = int'(fpa.index); m_bank = int'(fpa.bank);
        end
      end
      next_cycle();
    end
    nRST = 1'b1;
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    next_cycle();
    test_reset();
    test_dual_bank();
    test_fill();
    test_starvation();
    test_fill_accept_ld();
    test_reset_mid_fill();
    test_store_during_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_bank_arbiter.md
DCACHE_BANK_ARBITER -- requirements
Module: dcache_bank_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied store cycles before the store is forced to win.
REQ-002 SHALL have one clock and a synchronous, active-low reset:
  CLK  input  1  clock; all state updates on rising edge
  nRST  input  1  synchronous active-low reset
REQ-003 SHALL have the following request ports:
  ld_req_valid  input  1  load pipeline requests a dcache bank access
  ld_req_PA  input  dcache_PA_t (34)  load physical address
  ld_req_ready  output  1  load granted this cycle
  st_req_valid  input  1  write buffer requests a dcache bank access
  st_req_PA  input  dcache_PA_t (34)  store physical address
  st_req_ready  output  1  store granted this cycle
  fill_req_valid  input  1  miss return requests a block fill
  fill_req_PA  input  dcache_PA_t (34)  fill block address; block_offset ignored
  fill_req_ready  output  1  fill accepted this cycle
REQ-004 SHALL have the following fill-status and bank-access ports:
  fill_beat_valid  output  1  fill data beat issued this cycle
  fill_beat_idx  output  3  data word index within block, 0..7
  bank_access_valid  output  [1:0]  per-bank data array access enable
  bank_access_src  output  [1:0] x dcache_access_src_t  per-bank source: LD, ST or FILL
  bank_access_row  output  [1:0] x DCACHE_DATA_WORD_INDEX_WIDTH (9)  per-bank data row

Function
REQ-005 SHALL route each ld/st request to the bank given by PA.bank.
REQ-006 SHALL grant at most one access per bank per cycle; grants are combinational, same cycle as valid. Handshake completes on valid & ready.
REQ-007 SHALL compute the ld/st row as {PA.index, PA.block_offset[4:2]}.
REQ-008 SHALL implement fill FSM states IDLE and FILL; fill_req_ready = (state == IDLE).
REQ-009 SHALL, on fill accept in IDLE, latch index and bank, zero the beat counter and move to FILL next cycle.
REQ-010 SHALL, in FILL, issue one beat per cycle for 8 cycles (DCACHE_FILL_BEATS) to the latched bank: bank_access_src = FILL, row = {latched index, beat}, fill_beat_valid = 1, fill_beat_idx = beat.
REQ-011 SHALL return to IDLE after beat 7. The next fill is accepted no earlier than the cycle after beat 7.
REQ-012 SHALL deny ld and st to the latched bank while in FILL; the other bank remains available to ld/st.
REQ-013 SHALL still grant ld/st to the fill target bank in the fill-accept cycle; the lock starts the following cycle.
REQ-014 SHALL give ld priority over st when both target the same unlocked bank.
REQ-015 SHALL keep a store starvation counter, saturating at STARVE_LIMIT:
  - increments each cycle st_req_valid is high and st is denied
  - clears on st grant and when st_req_valid is low
REQ-016 SHALL make st win a same-bank conflict when the counter equals STARVE_LIMIT; ld is denied that cycle.
REQ-017 SHALL grant ld and st in the same cycle when they target different unlocked banks.
REQ-018 SHALL not count a st denial caused by a fill lock toward starvation. The counter holds during the lock.

Reset
REQ-019 SHALL, on nRST low at a clock edge, set: FSM = IDLE, beat counter = 0, starvation counter = 0, latched index/bank = 0.
REQ-020 SHALL abort a fill in progress on reset mid-FILL, with no further beats.
REQ-021 SHALL drive outputs while reset is asserted as follows:
  - fill_beat_valid = 0, bank_access_valid = 0
  - ld_req_ready = st_req_ready = 0
  - fill_req_ready = 0

Structure
REQ-022 SHALL add to system_types_pkg:
  - dcache_access_src_t (LD = 0, ST = 1, FILL = 2)
  - DCACHE_FILL_BEATS = DCACHE_BLOCK_SIZE / DCACHE_DATA_WORD_WIDTH
  - DCACHE_FILL_BEAT_WIDTH = $clog2(DCACHE_FILL_BEATS)
REQ-023 SHALL use dcache_PA_t and DCACHE_DATA_WORD_INDEX_WIDTH from system_types_pkg.
REQ-024 SHALL be a single module with no sub-module; per-bank grant logic is a generate loop over 2 banks.

Verification
REQ-025 Bench SHALL cover ld bank0 and st bank1, same cycle -> both ready = 1; bank_access_valid = 2'b11; src = {ST, LD}.
REQ-026 Bench SHALL cover fill to bank1, index 0x2A -> beats in the next 8 cycles:
  - rows 0x150..0x157 on bank1
  - fill_beat_idx 0..7
  - fill_req_ready = 0 throughout
  - ld to bank1 denied; ld to bank0 granted
REQ-027 Bench SHALL cover ld and st held valid to bank0, same row, with STARVE_LIMIT = 4 -> ld granted 4 cycles, st granted 5th cycle, then ld resumes.
REQ-028 Bench SHALL cover fill accept with ld to the same bank in the accept cycle -> ld granted that cycle; ld denied from next cycle for 8 cycles.
REQ-029 Bench SHALL cover nRST low at beat 3 of a fill -> no beat next cycle; fill_req_ready = 1 the cycle after reset deasserts.
REQ-030 Bench SHALL cover st held valid during an 8-cycle bank0 fill, ld idle -> counter stays 0; st granted on the first cycle after the lock.
